serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequencer that time-multiplexes one `fulladdder` instance (ports In1, In2, Cin, Sum, Cout) to add two WIDTH-bit operands bit-serially, LSB first.
- Exactly one `fulladdder` is instantiated inside. The controller owns the operand shift registers, the carry register, the bit counter and the start/busy/done handshake.
- Used wherever area matters more than latency: one add per WIDTH+1 cycles.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request a new add; sampled on rising edge.
- A  input  WIDTH  operand A; captured on accepted Start.
- B  input  WIDTH  operand B; captured on accepted Start.
- CinIn  input  1  carry-in; captured on accepted Start.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse; Sum and Cout are valid from this cycle on.
- Sum  output  WIDTH  registered result, held until the next completion.
- Cout  output  1  registered carry-out, held with Sum.

Behaviour:
- Reset (Rst=1 at an edge):
  - State goes to IDLE.
  - Busy=0, Done=0, Sum=0, Cout=0.
  - Shift registers, carry register and counter are cleared.
  - Rst overrides Start in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at edge k: load A_sh<=A, B_sh<=B, carry<=CinIn, cnt<=0, state<=RUN.
  - Start=0: stay in IDLE.
- RUN (Busy=1):
  - Full adder inputs are In1=A_sh[0], In2=B_sh[0], Cin=carry.
  - Each edge does all of the following:
    - carry<=Cout_fa.
    - acc<={Sum_fa, acc[WIDTH-1:1]}.
    - A_sh and B_sh shift right by 1.
    - cnt<=cnt+1.
  - Edge where cnt==WIDTH-1 (the last bit): Sum<={Sum_fa, acc[WIDTH-1:1]}, Cout<=Cout_fa, state<=DONE.
- Latency: Start sampled at edge k → RUN on edges k+1..k+WIDTH → Done=1 for exactly the cycle after edge k+WIDTH.
- DONE (Done=1, Busy=0):
  - Lasts exactly one cycle, then returns to IDLE.
  - Start=1 in the DONE cycle is accepted exactly as in IDLE (back-to-back adds, no dead cycle).
- Start while in RUN is ignored. Operands are not re-sampled; no error is flagged.
- Changes on A, B, CinIn outside the accepting edge have no effect.
- Sum/Cout change only on the completing edge, on reset, or never otherwise. They stay stable through the next operation until its completion.
- Arithmetic: {Cout,Sum} = A + B + CinIn, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts one edge; Done appears the cycle after edge k+1.
- Reset mid-RUN aborts the operation: the partial result is discarded, Sum=0 and Cout=0, and no Done pulse occurs.
- Counter wrap: unreachable, because cnt is cleared on every load and stops at WIDTH-1.

Test Plan:
1. WIDTH=8; A=0xFF, B=0x01, CinIn=0, Start at edge 0 → Busy=1 after edges 1..8, Done pulse after edge 8, Sum=0x00, Cout=1.
2. A=0x5A, B=0xA5, CinIn=1 → Sum=0x00, Cout=1; then A=0x12, B=0x34, CinIn=0 → Sum=0x46, Cout=0. Previous Sum is held until the new Done.
3. Exhaustive with WIDTH=3: all 128 combinations of A, B, CinIn, each started with Start in the DONE cycle of the previous add → {Cout,Sum}==A+B+CinIn every time, Done spacing exactly 4 cycles.
4. Start=1 with A=0x01 at edge 3 while RUN on an add of 0x10+0x20 → ignored; result Sum=0x30; exactly one Done pulse.
5. Rst=1 at edge 4 of a RUN on 0xFF+0xFF → Busy=0, Sum=0x00, Cout=0, no Done; a subsequent Start with 0x03+0x04 → Sum=0x07.
6. Rst=1 and Start=1 on the same edge → stays IDLE, Busy stays 0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that reuses one full adder, LSB first.
// An add takes WIDTH RUN cycles plus a one-cycle DONE pulse. A new add can
// be started during that DONE cycle.

module fulladdder (
    input  logic In1,
    input  logic In2,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = In1 ^ In2 ^ Cin;
    assign Cout = (In1 & In2) | (Cin & (In1 ^ In2));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CinIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_cout;

    fulladdder u_fa (
        .In1  (a_sh[0]),
        .In2  (b_sh[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Result bits enter at the MSB and walk down, so after WIDTH steps the
    // first (LSB) result bit sits at bit 0. Written as a shift so that
    // WIDTH=1 needs no special case.
    always_comb begin
        acc_nxt = WIDTH'({fa_sum, acc} >> 1);
    end

    // Sequencer: load on Start in IDLE/DONE, one bit per RUN edge, pulse Done.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= CinIn;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Start is deliberately ignored here; operands stay latched.
                    carry <= fa_cout;
                    acc   <= acc_nxt;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        Sum   <= acc_nxt;
                        Cout  <= fa_cout;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: table-driven WIDTH=8 adds plus directed corner
// sequences, and an exhaustive back-to-back sweep on a WIDTH=3 instance.

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int passed = 0;
    int total  = 0;
    logic [7:0] prev_sum;
    logic       prev_cout;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8), .CNT_W(6)) dut8 (
        .Clk(clk), .Rst(rst), .Start(start8), .A(a8), .B(b8), .CinIn(cin8),
        .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(3), .CNT_W(6)) dut3 (
        .Clk(clk), .Rst(rst), .Start(start3), .A(a3), .B(b3), .CinIn(cin3),
        .Busy(busy3), .Done(done3), .Sum(sum3), .Cout(cout3)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One WIDTH=8 add: Start for one cycle, then wait (bounded) for Done.
    // Checks Busy, that the old result is held mid-run, latency and result.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] esum, input logic ecout, input string tag);
        int lat;
        @(negedge clk); a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        chk({tag, " busy"}, {31'd0, busy8}, 32'd1);
        @(negedge clk);
        chk({tag, " held"}, {23'd0, cout8, sum8}, {23'd0, prev_cout, prev_sum});
        lat = 1;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " busy@done"}, {31'd0, busy8}, 32'd0);
        chk({tag, " result"}, {23'd0, cout8, sum8}, {23'd0, ecout, esum});
        prev_sum = esum; prev_cout = ecout;
        @(negedge clk);
        chk({tag, " done 1cyc"}, {31'd0, done8}, 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int   ndone, n;
        logic [3:0] exp3;
        logic [2:0] ea, eb;
        logic       ec;

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'd0, busy8}, 32'd0);
        chk("reset done", {31'd0, done8}, 32'd0);
        chk("reset result", {23'd0, cout8, sum8}, 32'd0);
        prev_sum = 8'h00; prev_cout = 1'b0;

        for (int i = 0; i < 8; i++)
            add8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                 $sformatf("vec%0d", i));

        // Start during RUN must be ignored.
        @(negedge clk); a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); a8 = 8'h01; b8 = 8'h00; start8 = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); start8 = 1'b0;
            if (done8) ndone++;
        end
        chk("ignore-start done count", ndone, 1);
        chk("ignore-start result", {23'd0, cout8, sum8}, 32'h030);
        chk("ignore-start idle", {31'd0, busy8}, 32'd0);

        // Reset mid-RUN aborts: no Done, cleared result.
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort busy", {31'd0, busy8}, 32'd0);
        chk("abort result", {23'd0, cout8, sum8}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        chk("abort no done", ndone, 0);
        prev_sum = 8'h00; prev_cout = 1'b0;
        add8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "after-abort");

        // Reset beats Start on the same edge.
        @(negedge clk); rst = 1'b1; start8 = 1'b1; a8 = 8'h05; b8 = 8'h06;
        @(negedge clk); rst = 1'b0; start8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy8 || done8) ndone++;
            @(negedge clk);
        end
        chk("rst-vs-start idle", ndone, 0);
        chk("rst-vs-start result", {23'd0, cout8, sum8}, 32'd0);

        // Exhaustive WIDTH=3, each add started in the previous DONE cycle.
        @(negedge clk);
        a3 = 3'd0; b3 = 3'd0; cin3 = 1'b0; start3 = 1'b1;
        for (int i = 0; i < 128; i++) begin
            ea = 3'(i >> 4); eb = 3'(i >> 1); ec = 1'(i);
            exp3 = {1'b0, ea} + {1'b0, eb} + {3'd0, ec};
            @(negedge clk); start3 = 1'b0;
            a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
            n = 1;
            while (!done3 && n < 12) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("w3 spacing %0d", i), n, 4);
            chk($sformatf("w3 sum %0d+%0d+%0d", ea, eb, ec), {28'd0, cout3, sum3}, {28'd0, exp3});
            if (i < 127) begin
                a3 = 3'((i + 1) >> 4); b3 = 3'((i + 1) >> 1); cin3 = 1'(i + 1);
                start3 = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
